// File: rtl/multdiv_seq_pkg.sv
// -----------------------------------------------------------------------------
// multdiv_seq_pkg
// Shared definitions for the sequential multiply/divide unit:
//   - state_t    : controller state encoding (IDLE, MUL, DIV, DONE)
//   - OP_ADD/SUB : opcodes understood by the shared add/sub alu
//   - MD_WIDTH   : operand/result width
//   - MD_ITER    : iterations per operation, one per clock
// -----------------------------------------------------------------------------
package multdiv_seq_pkg;

    localparam int MD_WIDTH = 32;
    localparam int MD_ITER  = 32;

    localparam logic [4:0] OP_ADD = 5'b00000;
    localparam logic [4:0] OP_SUB = 5'b00001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage : multdiv_seq_pkg

// File: rtl/alu.sv
// -----------------------------------------------------------------------------
// alu
// Combinational 32-bit add/sub ALU of the execute stage.
// Ports:
//   data_operandA, data_operandB : two's complement operands
//   ctrl_ALUopcode               : OP_ADD (A+B) or OP_SUB (A-B); others add
//   data_result                  : 32-bit sum/difference
//   isNotEqual                   : A != B
//   isLessThan                   : A < B (signed)
//   overflow                     : signed overflow of the add/sub
// -----------------------------------------------------------------------------
module alu
    import multdiv_seq_pkg::*;
(
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    input  logic [4:0]  ctrl_ALUopcode,
    output logic [31:0] data_result,
    output logic        isNotEqual,
    output logic        isLessThan,
    output logic        overflow
);

    logic        is_sub;
    logic [31:0] b_eff;

    // Subtraction is A + ~B + 1; overflow is judged on the effective addend so
    // the same rule covers both add and sub.
    always_comb begin
        is_sub      = (ctrl_ALUopcode == OP_SUB);
        b_eff       = is_sub ? ~data_operandB : data_operandB;
        data_result = data_operandA + b_eff + {31'd0, is_sub};
        overflow    = (data_operandA[31] == b_eff[31]) &&
                      (data_result[31] != data_operandA[31]);
        isNotEqual  = (data_operandA != data_operandB);
        isLessThan  = ($signed(data_operandA) < $signed(data_operandB));
    end

endmodule : alu

// File: rtl/multdiv_ctrl.sv
// -----------------------------------------------------------------------------
// multdiv_ctrl
// Sequencer for multdiv_seq: FSM plus iteration counter.
// Ports:
//   clock, reset   : clock and synchronous active-high reset
//   start_mul      : multiply start pulse (wins over start_div)
//   start_div      : divide start pulse
//   div_zero       : latched divisor is zero; skip straight to DONE
//   iterate        : datapath performs one Booth / division step this cycle
//   finish         : datapath loads the result registers this cycle
//   rdy            : high for the single cycle spent in DONE
// -----------------------------------------------------------------------------
module multdiv_ctrl
    import multdiv_seq_pkg::*;
#(
    parameter int ITER = MD_ITER
) (
    input  logic clock,
    input  logic reset,
    input  logic start_mul,
    input  logic start_div,
    input  logic div_zero,
    output logic iterate,
    output logic finish,
    output logic rdy
);

    localparam int              CNT_W    = $clog2(ITER + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // State and counter registers; reset wins over any start pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // A start pulse restarts from any state. Once the counter reaches ITER all
    // steps are done and the following edge loads the results and enters DONE.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        iterate = 1'b0;
        finish  = 1'b0;
        rdy     = (state_q == ST_DONE);

        if (start_mul) begin
            state_d = ST_MUL;
            count_d = '0;
        end else if (start_div) begin
            state_d = ST_DIV;
            count_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_IDLE;
                ST_MUL, ST_DIV: begin
                    if ((state_q == ST_DIV && div_zero) || count_q == CNT_LAST) begin
                        state_d = ST_DONE;
                        finish  = 1'b1;
                    end else begin
                        iterate = 1'b1;
                        count_d = count_q + CNT_W'(1);
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

endmodule : multdiv_ctrl

// File: rtl/multdiv_seq.sv
// -----------------------------------------------------------------------------
// multdiv_seq
// Multicycle signed 32-bit multiply (radix-2 Booth) / divide (restoring on
// magnitudes) unit sharing one add/sub alu for every iteration step.
// Ports:
//   clock, reset          : clock and synchronous active-high reset
//   data_operandA         : multiplicand / dividend
//   data_operandB         : multiplier / divisor
//   ctrl_MULT, ctrl_DIV   : one-cycle start pulses (MULT wins if both)
//   data_result           : low product word or truncated quotient
//   data_exception        : product overflow, divide by zero or MIN / -1
//   data_resultRDY        : one-cycle pulse when the result is valid
// -----------------------------------------------------------------------------
module multdiv_seq
    import multdiv_seq_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH,
    parameter int ITER  = MD_ITER
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY
);

    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    logic             start;
    logic             iterate;
    logic             finish;

    // acc_q doubles as the division remainder, q_q as multiplier / quotient,
    // mcand_q as multiplicand / divisor magnitude.
    logic             is_div_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] q_q;
    logic             q_m1_q;
    logic [WIDTH-1:0] mcand_q;
    logic             neg_q;
    logic             div_zero_q;
    logic             div_ovf_q;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] rem_shift;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [4:0]       alu_op;
    logic [WIDTH-1:0] alu_sum;
    logic             alu_ovf;
    logic             alu_ne_unused;
    logic             alu_lt_unused;
    logic             booth_add;
    logic [WIDTH-1:0] acc_pre;
    logic             shift_sign;
    logic             div_borrow;
    logic [WIDTH:0]   prod_hi;
    logic             mul_exc;
    logic [WIDTH-1:0] quo_signed;

    assign start = ctrl_MULT | ctrl_DIV;

    multdiv_ctrl #(
        .ITER(ITER)
    ) u_ctrl (
        .clock    (clock),
        .reset    (reset),
        .start_mul(ctrl_MULT),
        .start_div(ctrl_DIV),
        .div_zero (div_zero_q),
        .iterate  (iterate),
        .finish   (finish),
        .rdy      (data_resultRDY)
    );

    alu u_alu (
        .data_operandA (alu_a),
        .data_operandB (alu_b),
        .ctrl_ALUopcode(alu_op),
        .data_result   (alu_sum),
        .isNotEqual    (alu_ne_unused),
        .isLessThan    (alu_lt_unused),
        .overflow      (alu_ovf)
    );

    // Operand muxing for the shared alu plus the per-step next values.
    // Division compares unsigned magnitudes; the borrow of the subtraction is
    // recovered from the operand MSBs and the difference MSB. Booth's shift-in
    // bit is the true 33-bit sign, hence the overflow correction.
    always_comb begin
        a_mag     = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
        b_mag     = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
        rem_shift = {acc_q[WIDTH-2:0], q_q[WIDTH-1]};

        alu_a  = acc_q;
        alu_b  = mcand_q;
        alu_op = OP_ADD;
        if (is_div_q) begin
            alu_a  = rem_shift;
            alu_op = OP_SUB;
        end else if ({q_q[0], q_m1_q} == 2'b10) begin
            alu_op = OP_SUB;
        end

        booth_add  = ~is_div_q & (q_q[0] ^ q_m1_q);
        acc_pre    = booth_add ? alu_sum : acc_q;
        shift_sign = booth_add ? (alu_sum[WIDTH-1] ^ alu_ovf) : acc_q[WIDTH-1];

        div_borrow = (~rem_shift[WIDTH-1] & mcand_q[WIDTH-1]) |
                     (~(rem_shift[WIDTH-1] ^ mcand_q[WIDTH-1]) & alu_sum[WIDTH-1]);

        prod_hi    = {acc_q, q_q[WIDTH-1]};
        mul_exc    = ~((&prod_hi) | ~(|prod_hi));
        quo_signed = neg_q ? -q_q : q_q;
    end

    // Datapath registers: a start loads fresh operands, otherwise each
    // iterate cycle performs one Booth step or one shift-subtract step.
    always_ff @(posedge clock) begin
        if (reset) begin
            is_div_q   <= 1'b0;
            acc_q      <= '0;
            q_q        <= '0;
            q_m1_q     <= 1'b0;
            mcand_q    <= '0;
            neg_q      <= 1'b0;
            div_zero_q <= 1'b0;
            div_ovf_q  <= 1'b0;
        end else if (start) begin
            is_div_q <= ~ctrl_MULT;
            acc_q    <= '0;
            q_m1_q   <= 1'b0;
            if (ctrl_MULT) begin
                q_q        <= data_operandB;
                mcand_q    <= data_operandA;
                neg_q      <= 1'b0;
                div_zero_q <= 1'b0;
                div_ovf_q  <= 1'b0;
            end else begin
                q_q        <= a_mag;
                mcand_q    <= b_mag;
                neg_q      <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                div_zero_q <= (data_operandB == '0);
                div_ovf_q  <= (data_operandA == MIN_VAL) && (&data_operandB);
            end
        end else if (iterate) begin
            if (is_div_q) begin
                acc_q <= div_borrow ? rem_shift : alu_sum;
                q_q   <= {q_q[WIDTH-2:0], ~div_borrow};
            end else begin
                acc_q  <= {shift_sign, acc_pre[WIDTH-1:1]};
                q_q    <= {acc_pre[0], q_q[WIDTH-1:1]};
                q_m1_q <= q_q[0];
            end
        end
    end

    // Result registers only change when entering DONE, so they hold the last
    // answer until the next completed operation or a reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            data_result    <= '0;
            data_exception <= 1'b0;
        end else if (finish) begin
            if (is_div_q) begin
                data_result    <= div_zero_q ? '0 : quo_signed;
                data_exception <= div_zero_q | div_ovf_q;
            end else begin
                data_result    <= q_q;
                data_exception <= mul_exc;
            end
        end
    end

endmodule : multdiv_seq

// File: tb/tb_multdiv_seq.sv
// -----------------------------------------------------------------------------
// tb_multdiv_seq
// Directed, table-driven bench for multdiv_seq with hand-computed results,
// plus hand-written sequences for abort/restart, reset and start priority.
// -----------------------------------------------------------------------------
module tb_multdiv_seq;

    logic        clock;
    logic        reset;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic        is_div;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_res;
        logic        exp_exc;
        int          exp_lat;
    } vec_t;

    localparam int NVEC = 17;
    vec_t vecs[NVEC];

    multdiv_seq dut (
        .clock         (clock),
        .reset         (reset),
        .data_operandA (data_operandA),
        .data_operandB (data_operandB),
        .ctrl_MULT     (ctrl_MULT),
        .ctrl_DIV      (ctrl_DIV),
        .data_result   (data_result),
        .data_exception(data_exception),
        .data_resultRDY(data_resultRDY)
    );

    // Free-running 10 ns clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Safety net in case the DUT wedges the bench somewhere unexpected.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Drives one start pulse on the next edge; returns #1 after that edge.
    task automatic applyStimulus(input logic mul, input logic div,
                                 input logic [31:0] a, input logic [31:0] b);
        ctrl_MULT     = mul;
        ctrl_DIV      = div;
        data_operandA = a;
        data_operandB = b;
        @(posedge clock);
        #1;
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
    endtask

    // Counts edges after the start edge until RDY is seen; -1 on timeout.
    task automatic waitResult(input int budget, output int lat);
        lat = -1;
        for (int k = 1; k <= budget; k++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) begin
                lat = k;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        int rdy_count;
        int first_lat;
        logic [31:0] cap_res;
        logic        cap_exc;

        vecs[0]  = '{1'b0, 32'd7,         32'hFFFFFFFA, 32'hFFFFFFD6, 1'b0, 33};
        vecs[1]  = '{1'b0, 32'h00010000,  32'h00010000, 32'h00000000, 1'b1, 33};
        vecs[2]  = '{1'b0, 32'h80000000,  32'd1,        32'h80000000, 1'b0, 33};
        vecs[3]  = '{1'b0, 32'h80000000,  32'hFFFFFFFF, 32'h80000000, 1'b1, 33};
        vecs[4]  = '{1'b0, 32'hFFFFFFFD,  32'hFFFFFFFB, 32'd15,       1'b0, 33};
        vecs[5]  = '{1'b0, 32'h7FFFFFFF,  32'd2,        32'hFFFFFFFE, 1'b1, 33};
        vecs[6]  = '{1'b0, 32'h80000000,  32'h80000000, 32'h00000000, 1'b1, 33};
        vecs[7]  = '{1'b0, 32'd0,         32'd12345,    32'd0,        1'b0, 33};
        vecs[8]  = '{1'b1, 32'hFFFFFFF9,  32'd2,        32'hFFFFFFFD, 1'b0, 33};
        vecs[9]  = '{1'b1, 32'h80000000,  32'hFFFFFFFF, 32'h80000000, 1'b1, 33};
        vecs[10] = '{1'b1, 32'd100,       32'd0,        32'd0,        1'b1, 1};
        vecs[11] = '{1'b1, 32'd100,       32'd7,        32'd14,       1'b0, 33};
        vecs[12] = '{1'b1, 32'd7,         32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0, 33};
        vecs[13] = '{1'b1, 32'hFFFFFF9C,  32'hFFFFFFF6, 32'd10,       1'b0, 33};
        vecs[14] = '{1'b1, 32'h80000000,  32'd2,        32'hC0000000, 1'b0, 33};
        vecs[15] = '{1'b1, 32'd5,         32'd7,        32'd0,        1'b0, 33};
        vecs[16] = '{1'b1, 32'h7FFFFFFF,  32'd1,        32'h7FFFFFFF, 1'b0, 33};

        reset         = 1'b1;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        repeat (3) @(posedge clock);
        #1;
        checkOutput("reset_result", data_result, 32'd0);
        checkOutput("reset_exc", {31'd0, data_exception}, 32'd0);
        checkOutput("reset_rdy", {31'd0, data_resultRDY}, 32'd0);
        reset = 1'b0;
        @(posedge clock);
        #1;
        checkOutput("idle_rdy", {31'd0, data_resultRDY}, 32'd0);

        // Table of single operations: latency, result, exception, RDY width.
        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(~vecs[i].is_div, vecs[i].is_div, vecs[i].a, vecs[i].b);
            waitResult(40, lat);
            checkOutput($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            checkOutput($sformatf("v%0d_result", i), data_result, vecs[i].exp_res);
            checkOutput($sformatf("v%0d_exc", i), {31'd0, data_exception},
                        {31'd0, vecs[i].exp_exc});
            @(posedge clock);
            #1;
            checkOutput($sformatf("v%0d_rdy_drop", i), {31'd0, data_resultRDY}, 32'd0);
            checkOutput($sformatf("v%0d_hold", i), data_result, vecs[i].exp_res);
        end

        // MULT 3*4 aborted at cycle 10 by DIV 20/5: one RDY, 33 after DIV edge.
        rdy_count = 0;
        first_lat = -1;
        cap_res   = '0;
        cap_exc   = 1'b0;
        applyStimulus(1'b1, 1'b0, 32'd3, 32'd4);
        repeat (9) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) rdy_count++;
        end
        applyStimulus(1'b0, 1'b1, 32'd20, 32'd5);
        for (int k = 1; k <= 40; k++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) begin
                rdy_count++;
                if (first_lat < 0) begin
                    first_lat = k;
                    cap_res   = data_result;
                    cap_exc   = data_exception;
                end
            end
        end
        checkOutput("abort_latency", 32'(first_lat), 32'd33);
        checkOutput("abort_rdy_count", 32'(rdy_count), 32'd1);
        checkOutput("abort_result", cap_res, 32'd4);
        checkOutput("abort_exc", {31'd0, cap_exc}, 32'd0);

        // Reset at cycle 15 of a MULT: outputs cleared, no RDY afterwards.
        applyStimulus(1'b1, 1'b0, 32'd5, 32'd5);
        repeat (14) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        checkOutput("midreset_result", data_result, 32'd0);
        checkOutput("midreset_exc", {31'd0, data_exception}, 32'd0);
        checkOutput("midreset_rdy", {31'd0, data_resultRDY}, 32'd0);
        rdy_count = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) rdy_count++;
        end
        checkOutput("midreset_no_rdy", 32'(rdy_count), 32'd0);

        // Both starts high: multiply takes priority, 3*3 = 9 (not 3/3 = 1).
        applyStimulus(1'b1, 1'b1, 32'd3, 32'd3);
        waitResult(40, lat);
        checkOutput("prio_latency", 32'(lat), 32'd33);
        checkOutput("prio_result", data_result, 32'd9);
        checkOutput("prio_exc", {31'd0, data_exception}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule : tb_multdiv_seq
